// File: rtl/crash_course_cpu_control.sv
// Fetch/decode/sequencing front end of the crash-course CPU: owns the PC, fetches
// 16-bit instructions over valid/ready, decodes them and resolves jumps/branches.
module crash_course_cpu_control #(
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic        clk,
  input  logic        sync_rst,
  input  logic        clk_en,
  input  logic        system_enabled,
  output logic        instr_req_valid,
  input  logic        instr_req_ready,
  output logic [7:0]  instr_addr,
  input  logic        instr_resp_valid,
  input  logic [15:0] instr_data,
  input  logic [1:0]  flag_register,
  output logic [3:0]  reg_a_addr,
  output logic [3:0]  reg_b_addr,
  output logic [3:0]  reg_c_addr,
  output logic [7:0]  immediate,
  output logic [3:0]  opcode,
  output logic        reg_a_write_enable,
  output logic        mem_write_enable,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_EXEC,
    S_HALTED
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        req_valid_q, req_valid_d;
  logic        reg_we_q, reg_we_d;
  logic        mem_we_q, mem_we_d;
  logic        halted_q, halted_d;

  // ALU, LOADI and LOAD opcodes write reg_a; STORE (0x3) and control ops do not.
  function automatic logic writes_reg(input logic [3:0] op);
    writes_reg = (op <= 4'hB) && (op != 4'h3);
  endfunction

  function automatic logic [7:0] next_pc(input logic [15:0] ir,
                                         input logic [7:0]  pc,
                                         input logic [1:0]  flags);
    logic [7:0] target;
    logic [7:0] seq;
    target = ir[7:0];
    seq    = pc + 8'd1;
    case (ir[15:12])
      4'hC:    next_pc = target;
      4'hD:    next_pc = flags[0] ? target : seq;
      4'hE:    next_pc = flags[1] ? target : seq;
      default: next_pc = seq;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (system_enabled) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (instr_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (instr_resp_valid) begin
          ir_d    = instr_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        pc_d = next_pc(ir_q, pc_q, flag_register);
        if (ir_q[15:12] == 4'hF)  state_d = S_HALTED;
        else if (system_enabled)  state_d = S_FETCH;
        else                      state_d = S_IDLE;
      end
      default: begin
        state_d = state_q;
      end
    endcase

    // Outputs are decoded from the next state so they come straight off flops.
    req_valid_d = (state_d == S_FETCH);
    reg_we_d    = (state_d == S_EXEC) && writes_reg(ir_d[15:12]);
    mem_we_d    = (state_d == S_EXEC) && (ir_d[15:12] == 4'h3);
    halted_d    = (state_d == S_HALTED);
  end

  always_ff @(posedge clk) begin
    if (!sync_rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      ir_q        <= 16'h0000;
      req_valid_q <= 1'b0;
      reg_we_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      halted_q    <= 1'b0;
    end else if (clk_en) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      req_valid_q <= req_valid_d;
      reg_we_q    <= reg_we_d;
      mem_we_q    <= mem_we_d;
      halted_q    <= halted_d;
    end
  end

  assign instr_req_valid    = req_valid_q;
  assign instr_addr         = pc_q;
  assign opcode             = ir_q[15:12];
  assign reg_a_addr         = ir_q[11:8];
  assign reg_b_addr         = ir_q[7:4];
  assign reg_c_addr         = ir_q[3:0];
  assign immediate          = ir_q[7:0];
  assign reg_a_write_enable = reg_we_q;
  assign mem_write_enable   = mem_we_q;
  assign halted             = halted_q;

endmodule

// File: tb/tb_crash_course_cpu_control.sv
// Scoreboard bench for crash_course_cpu_control: directed programs in a bench memory,
// expected fetches/executes/output snapshots queued by stimulus and checked by a monitor.
module tb_crash_course_cpu_control;

  logic        clk = 1'b0;
  logic        sync_rst, clk_en, system_enabled;
  logic        instr_req_valid, instr_req_ready;
  logic [7:0]  instr_addr;
  logic        instr_resp_valid;
  logic [15:0] instr_data;
  logic [1:0]  flag_register;
  logic [3:0]  reg_a_addr, reg_b_addr, reg_c_addr, opcode;
  logic [7:0]  immediate;
  logic        reg_a_write_enable, mem_write_enable, halted;

  crash_course_cpu_control #(.RESET_PC(8'h00)) dut (
    .clk(clk), .sync_rst(sync_rst), .clk_en(clk_en), .system_enabled(system_enabled),
    .instr_req_valid(instr_req_valid), .instr_req_ready(instr_req_ready),
    .instr_addr(instr_addr), .instr_resp_valid(instr_resp_valid), .instr_data(instr_data),
    .flag_register(flag_register), .reg_a_addr(reg_a_addr), .reg_b_addr(reg_b_addr),
    .reg_c_addr(reg_c_addr), .immediate(immediate), .opcode(opcode),
    .reg_a_write_enable(reg_a_write_enable), .mem_write_enable(mem_write_enable),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct { string name; logic [7:0] addr; int gap; } fetch_t;
  typedef struct { string name; logic [25:0] val; } exec_t;
  typedef struct { string name; logic [35:0] val; } snap_t;

  fetch_t fetch_q[$];
  exec_t  exec_q[$];
  snap_t  snap_q[$];

  logic [15:0] mem [256];
  int checks = 0;
  int errors = 0;
  int n_fetch = 0;
  int resp_delay = 0;
  bit done = 0;

  // {opcode, a, b, c, imm, reg_we, mem_we}
  function automatic logic [25:0] ev(input logic [3:0] op, input logic [3:0] a,
                                     input logic [3:0] b, input logic [3:0] c,
                                     input logic [7:0] imm, input logic we, input logic mwe);
    return {op, a, b, c, imm, we, mwe};
  endfunction

  // {req_valid, addr, exec fields, halted}
  function automatic logic [35:0] sv(input logic rv, input logic [7:0] addr,
                                     input logic [25:0] e, input logic h);
    return {rv, addr, e, h};
  endfunction

  task automatic cmp(input string name, input logic [35:0] act, input logic [35:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic exp_fetch(input string n, input logic [7:0] a, input int g);
    fetch_t f;
    f.name = n; f.addr = a; f.gap = g;
    fetch_q.push_back(f);
  endtask

  task automatic exp_exec(input string n, input logic [25:0] v);
    exec_t e;
    e.name = n; e.val = v;
    exec_q.push_back(e);
  endtask

  task automatic snap(input string n, input logic [35:0] v);
    snap_t s;
    s.name = n; s.val = v;
    snap_q.push_back(s);
  endtask

  task automatic do_reset;
    sync_rst = 1'b0;
    system_enabled = 1'b0;
    instr_req_ready = 1'b0;
    tick;
    sync_rst = 1'b1;
    snap("reset", sv(1'b0, 8'h00, ev(4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0), 1'b0));
  endtask

  task automatic wait_halted(input string n);
    int i;
    i = 0;
    while (!halted && i < 300) begin
      tick;
      i++;
    end
    if (!halted) begin
      $display("FAIL %s_timeout: halted=%0b, required 1", n, halted);
      $fatal(1, "halt wait expired");
    end
  endtask

  // Bench memory: answers an accepted fetch after resp_delay enabled cycles.
  logic       r_hs, r_take, r_en, r_active;
  int         r_cnt;
  logic [7:0] r_paddr, r_addr;
  initial begin
    r_hs = 0; r_take = 0; r_en = 0; r_active = 0; r_cnt = 0; r_paddr = 0; r_addr = 0;
    instr_resp_valid = 1'b0;
    instr_data = 16'h0000;
    forever begin
      @(negedge clk);
      if (!sync_rst) begin
        r_active = 0; r_hs = 0; r_take = 0;
        instr_resp_valid = 1'b0;
      end else begin
        if (r_take) begin
          instr_resp_valid = 1'b0;
          r_active = 0;
        end
        if (r_hs) begin
          r_active = 1; r_cnt = resp_delay; r_addr = r_paddr;
        end else if (r_active && !instr_resp_valid && r_en && r_cnt > 0) begin
          r_cnt--;
        end
        if (r_active && !instr_resp_valid && r_cnt == 0) begin
          instr_resp_valid = 1'b1;
          instr_data = mem[r_addr];
        end
        r_hs    = instr_req_valid && instr_req_ready && clk_en;
        r_take  = instr_resp_valid && clk_en;
        r_paddr = instr_addr;
      end
      r_en = clk_en;
    end
  end

  // Monitor / scoreboard.
  int   m_cyc, m_last;
  logic m_en;
  initial begin
    fetch_t f;
    exec_t  e;
    snap_t  s;
    m_cyc = 0; m_last = 0; m_en = 0;
    forever begin
      @(negedge clk);
      if (m_en) m_cyc++;
      if (m_en && (reg_a_write_enable || mem_write_enable)) begin
        if (exec_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_exec: got op %h we %0b mwe %0b, required no pulse",
                   opcode, reg_a_write_enable, mem_write_enable);
        end else begin
          e = exec_q.pop_front();
          cmp(e.name, {10'd0, opcode, reg_a_addr, reg_b_addr, reg_c_addr, immediate,
                       reg_a_write_enable, mem_write_enable}, {10'd0, e.val});
        end
      end
      if (instr_req_valid && instr_req_ready && clk_en && sync_rst) begin
        n_fetch++;
        if (fetch_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_fetch: got addr %h, required no request", instr_addr);
        end else begin
          f = fetch_q.pop_front();
          cmp(f.name, {28'd0, instr_addr}, {28'd0, f.addr});
          if (f.gap >= 0) cmp({f.name, "_gap"}, 36'(m_cyc - m_last), 36'(f.gap));
        end
        m_last = m_cyc;
      end
      if (snap_q.size() > 0) begin
        s = snap_q.pop_front();
        cmp(s.name, {instr_req_valid, instr_addr, opcode, reg_a_addr, reg_b_addr, reg_c_addr,
                     immediate, reg_a_write_enable, mem_write_enable, halted}, s.val);
      end
      if (done) begin
        cmp("fetch_q_drained", 36'(fetch_q.size()), 36'd0);
        cmp("exec_q_drained", 36'(exec_q.size()), 36'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
      m_en = clk_en;
    end
  end

  // Stimulus.
  initial begin
    logic [35:0] v;
    int base, i;
    sync_rst = 1'b0; clk_en = 1'b1; system_enabled = 1'b0;
    instr_req_ready = 1'b0; flag_register = 2'b00;
    foreach (mem[k]) mem[k] = 16'hF000;

    // Straight-line program: LOADI r10,5; 0x4ABC; HALT
    mem[8'h00] = 16'h1A05; mem[8'h01] = 16'h4ABC; mem[8'h02] = 16'hF000;
    do_reset;
    instr_req_ready = 1'b1; resp_delay = 0;
    exp_fetch("t1_f0", 8'h00, -1);
    exp_exec("t1_loadi", ev(4'h1, 4'hA, 4'h0, 4'h5, 8'h05, 1'b1, 1'b0));
    exp_fetch("t1_f1", 8'h01, 3);
    exp_exec("t1_op4", ev(4'h4, 4'hA, 4'hB, 4'hC, 8'hBC, 1'b1, 1'b0));
    exp_fetch("t1_f2", 8'h02, 3);
    system_enabled = 1'b1;
    wait_halted("t1");
    v = sv(1'b0, 8'h03, ev(4'hF, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0), 1'b1);
    snap("t1_halted", v);
    repeat (4) begin tick; snap("t1_halted_hold", v); end
    do_reset;

    // STORE
    mem[8'h00] = 16'h3034; mem[8'h01] = 16'hF000;
    instr_req_ready = 1'b1;
    exp_fetch("st_f0", 8'h00, -1);
    exp_exec("store", ev(4'h3, 4'h0, 4'h3, 4'h4, 8'h34, 1'b0, 1'b1));
    exp_fetch("st_f1", 8'h01, -1);
    system_enabled = 1'b1;
    wait_halted("store");
    do_reset;

    // BRZ taken, BRZ not taken, BRC taken (all reached by JMP 0x10)
    mem[8'h00] = 16'hC010; mem[8'h10] = 16'hD040; mem[8'h40] = 16'hF000; mem[8'h11] = 16'hF000;
    flag_register = 2'b01; instr_req_ready = 1'b1;
    exp_fetch("brz_f0", 8'h00, -1); exp_fetch("jmp_10", 8'h10, -1); exp_fetch("brz_taken", 8'h40, -1);
    system_enabled = 1'b1;
    wait_halted("brz_t");
    do_reset;
    flag_register = 2'b00; instr_req_ready = 1'b1;
    exp_fetch("brz_f0", 8'h00, -1); exp_fetch("jmp_10", 8'h10, -1); exp_fetch("brz_not", 8'h11, -1);
    system_enabled = 1'b1;
    wait_halted("brz_n");
    do_reset;
    mem[8'h10] = 16'hE050; mem[8'h50] = 16'hF000;
    flag_register = 2'b10; instr_req_ready = 1'b1;
    exp_fetch("brc_f0", 8'h00, -1); exp_fetch("jmp_10", 8'h10, -1); exp_fetch("brc_taken", 8'h50, -1);
    system_enabled = 1'b1;
    wait_halted("brc");
    do_reset;

    // JMP 0xFF then a plain op at 0xFF: PC wraps to 0x00
    mem[8'h00] = 16'hC0FF; mem[8'hFF] = 16'h1234;
    flag_register = 2'b00; instr_req_ready = 1'b1;
    exp_fetch("wrap_f0", 8'h00, -1); exp_fetch("jmp_ff", 8'hFF, -1);
    exp_exec("wrap_op", ev(4'h1, 4'h2, 4'h3, 4'h4, 8'h34, 1'b1, 1'b0));
    exp_fetch("pc_wrap", 8'h00, -1);
    base = n_fetch;
    system_enabled = 1'b1;
    i = 0;
    while (n_fetch < base + 2 && i < 100) begin tick; i++; end
    if (n_fetch < base + 2) begin
      $display("FAIL wrap_timeout: fetches %0d, required %0d", n_fetch - base, 2);
      $fatal(1, "fetch wait expired");
    end
    mem[8'h00] = 16'hF000;
    wait_halted("wrap");
    do_reset;

    // Backpressure: ready low, slow response, clk_en freeze in WAIT and EXECUTE
    mem[8'h00] = 16'h1A05; mem[8'h01] = 16'hF000;
    resp_delay = 5;
    exp_fetch("bp_f0", 8'h00, -1);
    exp_exec("bp_exec", ev(4'h1, 4'hA, 4'h0, 4'h5, 8'h05, 1'b1, 1'b0));
    exp_fetch("bp_f1", 8'h01, -1);
    system_enabled = 1'b1;
    tick;
    v = sv(1'b1, 8'h00, ev(4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0), 1'b0);
    repeat (4) begin snap("bp_hold", v); tick; end
    snap("bp_hold", v);
    instr_req_ready = 1'b1;
    tick;
    v = sv(1'b0, 8'h00, ev(4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0), 1'b0);
    snap("bp_wait", v);
    tick;
    snap("bp_wait", v);
    clk_en = 1'b0;
    repeat (3) begin tick; snap("bp_frozen", v); end
    clk_en = 1'b1;
    i = 0;
    tick;
    while (!reg_a_write_enable && i < 20) begin
      snap("bp_wait", v);
      tick;
      i++;
    end
    if (!reg_a_write_enable) begin
      $display("FAIL bp_exec_timeout: we=%0b, required 1", reg_a_write_enable);
      $fatal(1, "exec wait expired");
    end
    clk_en = 1'b0;
    v = sv(1'b0, 8'h00, ev(4'h1, 4'hA, 4'h0, 4'h5, 8'h05, 1'b1, 1'b0), 1'b0);
    snap("bp_stretch", v);
    repeat (2) begin tick; snap("bp_stretch", v); end
    clk_en = 1'b1;
    wait_halted("bp");
    do_reset;

    // system_enabled dropped in WAIT: instruction completes, then IDLE
    mem[8'h00] = 16'h4ABC;
    resp_delay = 2; instr_req_ready = 1'b1;
    exp_fetch("sd_f0", 8'h00, -1);
    exp_exec("sd_exec", ev(4'h4, 4'hA, 4'hB, 4'hC, 8'hBC, 1'b1, 1'b0));
    system_enabled = 1'b1;
    tick;
    tick;
    system_enabled = 1'b0;
    snap("sd_wait", sv(1'b0, 8'h00, ev(4'h0, 4'h0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0), 1'b0));
    i = 0;
    while (!reg_a_write_enable && i < 20) begin tick; i++; end
    if (!reg_a_write_enable) begin
      $display("FAIL sd_exec_timeout: we=%0b, required 1", reg_a_write_enable);
      $fatal(1, "exec wait expired");
    end
    tick;
    v = sv(1'b0, 8'h01, ev(4'h4, 4'hA, 4'hB, 4'hC, 8'hBC, 1'b0, 1'b0), 1'b0);
    snap("sd_idle", v);
    repeat (3) begin tick; snap("sd_idle", v); end

    // Reset asserted while a request is pending
    instr_req_ready = 1'b0;
    system_enabled = 1'b1;
    tick;
    snap("rf_fetch", sv(1'b1, 8'h01, ev(4'h4, 4'hA, 4'hB, 4'hC, 8'hBC, 1'b0, 1'b0), 1'b0));
    do_reset;
    tick;

    done = 1'b1;
    repeat (10) @(posedge clk);
    $display("FAIL monitor_stall: summary not reached, required completion");
    $fatal(1, "monitor did not finish");
  end

endmodule

// File: doc/crash_course_cpu_control.md
# crash_course_cpu_control

Fetch/decode/sequencing stage for the crash-course CPU. It sits directly upstream of `crash_course_cpu_dataloop`. It holds the program counter and fetches 16-bit instructions over a valid/ready request port. It decodes each instruction into the register addresses, immediate, opcode and write enable the dataloop consumes. It resolves jumps and flag-conditional branches using the dataloop's `flag_register`.

## Interface
Parameters:
- `RESET_PC`, 8'h00: program counter value after reset.

Ports:
- `clk` in 1: system clock.
- `sync_rst` in 1: synchronous, active-low reset (0 = reset).
- `clk_en` in 1: global clock enable. When low, all state is frozen.
- `system_enabled` in 1: run permission, sampled only before issuing a new fetch.
- `instr_req_valid` out 1: fetch request.
- `instr_req_ready` in 1: fetch request accepted.
- `instr_addr` out 8: fetch address, equal to the PC.
- `instr_resp_valid` in 1: instruction data valid.
- `instr_data` in 16: fetched instruction.
- `flag_register` in 2: bit 0 = zero, bit 1 = carry. Comes from the dataloop.
- `reg_a_addr` out 4: `instr_data[11:8]` of the current instruction.
- `reg_b_addr` out 4: `instr_data[7:4]`.
- `reg_c_addr` out 4: `instr_data[3:0]`.
- `immediate` out 8: `instr_data[7:0]`.
- `opcode` out 4: `instr_data[15:12]`.
- `reg_a_write_enable` out 1: one-cycle pulse in EXECUTE for register-writing opcodes.
- `mem_write_enable` out 1: one-cycle pulse in EXECUTE for STORE.
- `halted` out 1: high once a HALT instruction has executed.

## Operation
- An instruction register (IR) captures `instr_data` when `instr_resp_valid` is high in the WAIT state. All decoded field outputs come from the IR. They stay stable until the next capture.
- Opcode classes:
  - 0x0–0x2 and 0x4–0xB: ALU, LOADI or LOAD ops. These assert `reg_a_write_enable`.
  - 0x3 STORE: asserts `mem_write_enable`, no register write.
  - 0xC JMP: sets PC = immediate.
  - 0xD BRZ: sets PC = immediate if `flag_register[0]`, otherwise PC+1.
  - 0xE BRC: same as BRZ, using `flag_register[1]`.
  - 0xF HALT.
  - Opcodes 0xC–0xF assert neither write enable.
- Every other opcode sets PC = PC+1 in EXECUTE. The PC is 8 bits and wraps 0xFF → 0x00.
- State machine:
  - IDLE: go to FETCH if `system_enabled`.
  - FETCH: `instr_req_valid`=1. On `instr_req_ready`, go to WAIT. Otherwise hold `instr_req_valid` and `instr_addr` stable.
  - WAIT: on `instr_resp_valid`, capture the IR and go to EXECUTE.
  - EXECUTE: lasts exactly 1 cycle. Pulse the enables and update the PC. Then:
    - HALT goes to HALTED.
    - Otherwise, if `system_enabled`, go to FETCH; if not, go to IDLE.
  - HALTED: terminal. `halted`=1. Leaves only on reset.
- Branches sample `flag_register` during their EXECUTE cycle. The flags reflect every instruction retired earlier, because the dataloop updates them at the end of each EXECUTE cycle and at least 2 cycles separate consecutive EXECUTEs.
- Dropping `system_enabled` mid-instruction does not abort it. An accepted fetch always completes through EXECUTE.
- `instr_resp_valid` outside WAIT is ignored.

## Timing
- Reset values:
  - PC = `RESET_PC`, state = IDLE, IR = 16'h0000.
  - `instr_req_valid` = 0, `reg_a_write_enable` = 0, `mem_write_enable` = 0, `halted` = 0.
  - All field outputs = 0.
- Reset takes priority over `clk_en`.
- With `clk_en` low, state, PC, IR and outputs hold their values. An enable pulse stretches until the next enabled edge.
- Handshakes:
  - The request transfers on a cycle with `instr_req_valid` and `instr_req_ready` both high.
  - A response is accepted no earlier than the cycle after request acceptance.
- Best case is 3 enabled cycles per instruction: FETCH, WAIT, EXECUTE.
- `reg_a_write_enable` and `mem_write_enable` are high only in EXECUTE and never both at once.
- Reset asserted in any state, including mid-fetch, returns to the reset values on the next edge. Any outstanding response is dropped.

## Test plan
- Reset with ready=1 and a single-cycle response latency, running 0x1A05 (LOADI r10, 5) then 0x4ABC:
  - Fetch addresses 0x00 then 0x01.
  - Instruction 1 EXECUTE: `reg_a_addr`=0xA, `immediate`=0x05, `opcode`=1, we=1.
  - Instructions start 3 cycles apart.
- STORE 0x3034: `mem_write_enable`=1, `reg_a_write_enable`=0, `reg_b_addr`=3, `reg_c_addr`=4.
- Branches at PC 0x10:
  - BRZ 0xD040 with flags=2'b01: next fetch address is 0x40.
  - Same instruction with flags=2'b00: next fetch address is 0x11.
  - JMP 0xC0FF, then a non-branch at 0xFF: next fetch address is 0x00 (wrap).
- Backpressure:
  - Hold ready=0 for 4 cycles: `instr_req_valid` and `instr_addr` stay stable.
  - Delay the response by 5 cycles: no enable pulses are produced.
  - Toggle `clk_en` low mid-WAIT: state is frozen.
- HALT 0xF000: `halted`=1 and no further requests, even with `system_enabled`=1. `sync_rst`=0 for one cycle returns to PC 0x00 and IDLE.
- `system_enabled` dropped in WAIT: EXECUTE still completes, then IDLE. Asserting `sync_rst`=0 during FETCH clears `instr_req_valid` on the next edge.
